// File: rtl/exu_trap_ctrl.sv
// Trap sequencer for the EXU exception path.
// Accepts one exception at a time from the LSU or the ALU, flushes the pipeline, writes
// mepc/mcause/mtval through the CSR write port and redirects fetch to mtvec. An ebreak skips
// the CSR/redirect sequence and parks the core in HALT with the a0 exit code latched.
module exu_trap_ctrl #(
   parameter int unsigned XLEN       = 32,
   parameter logic [11:0] CSR_MEPC   = 12'h341,
   parameter logic [11:0] CSR_MCAUSE = 12'h342,
   parameter logic [11:0] CSR_MTVAL  = 12'h343,
   parameter int unsigned FLUSH_TMO  = 15
) (
   input  logic            clk,
   input  logic            rst,
   // ALU exception request
   input  logic            alu_excp_valid,
   output logic            alu_excp_ready,
   input  logic            alu_excp_ebreak,
   input  logic            alu_excp_ecall,
   input  logic            alu_excp_illegal,
   input  logic [XLEN-1:0] alu_excp_pc,
   // LSU exception request
   input  logic            lsu_excp_valid,
   output logic            lsu_excp_ready,
   input  logic            lsu_excp_ld_mis,
   input  logic [XLEN-1:0] lsu_excp_pc,
   input  logic [XLEN-1:0] lsu_excp_badaddr,
   // Pipeline flush
   output logic            flush_req,
   input  logic            flush_ack,
   // CSR write port
   output logic            csr_wr_en,
   output logic [11:0]     csr_wr_addr,
   output logic [XLEN-1:0] csr_wr_data,
   input  logic [XLEN-1:0] csr_mtvec,
   // Fetch redirect
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready,
   // Commit / simulator interface
   input  logic [XLEN-1:0] endcode,
   output logic            commit_trap,
   output logic [XLEN-1:0] cmt_cause,
   output logic            halt,
   output logic [XLEN-1:0] halt_code,
   output logic            err_flush_tmo
);

   typedef enum logic [2:0] {
      StIdle,
      StFlush,
      StWrEpc,
      StWrCause,
      StWrTval,
      StRedir,
      StHalt
   } state_e;

   // Counter value seen in the last FLUSH cycle we are willing to spend waiting for ack.
   localparam logic [3:0] FlushLast = 4'(FLUSH_TMO - 1);

   state_e          state_q;
   logic [3:0]      flush_cnt_q;
   logic [XLEN-1:0] epc_q;
   logic [XLEN-1:0] tval_q;
   logic            ebreak_q;

   logic            lsu_accept;
   logic            alu_accept;
   logic            any_accept;
   logic [4:0]      acc_cause;
   logic [XLEN-1:0] acc_pc;
   logic [XLEN-1:0] acc_tval;
   logic            acc_ebreak;
   logic            flush_tmo;
   logic            flush_done;
   logic            redir_done;

   // Handshakes: LSU has priority because its instruction is older.
   assign lsu_excp_ready = (state_q == StIdle);
   assign alu_excp_ready = (state_q == StIdle) & ~lsu_excp_valid;
   assign lsu_accept     = lsu_excp_valid & lsu_excp_ready;
   assign alu_accept     = alu_excp_valid & alu_excp_ready;
   assign any_accept     = lsu_accept | alu_accept;

   // FLUSH ends on ack, or gives up on the last allowed cycle without ack.
   assign flush_tmo  = ~flush_ack & (flush_cnt_q == FlushLast);
   assign flush_done = (state_q == StFlush) & (flush_ack | flush_tmo);
   assign redir_done = (state_q == StRedir) & redirect_ready;

   // Commit must coincide with the completing handshake so a new trap can be taken next cycle.
   assign commit_trap = (flush_done & ebreak_q) | redir_done;

   // Decode cause, faulting pc and mtval of the request being accepted this cycle.
   always_comb begin
      acc_cause  = 5'h1F;
      acc_pc     = alu_excp_pc;
      acc_tval   = '0;
      acc_ebreak = 1'b0;
      if (lsu_excp_valid) begin
         acc_cause = lsu_excp_ld_mis ? 5'd4 : 5'd6;
         acc_pc    = lsu_excp_pc;
         acc_tval  = lsu_excp_badaddr;
      end else if (alu_excp_illegal) begin
         acc_cause = 5'd2;
      end else if (alu_excp_ecall) begin
         acc_cause = 5'd11;
      end else if (alu_excp_ebreak) begin
         acc_cause  = 5'd3;
         acc_ebreak = 1'b1;
      end
   end

   // Trap sequencer; every strobe is registered on entry to the state that owns it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= StIdle;
         flush_cnt_q    <= '0;
         epc_q          <= '0;
         tval_q         <= '0;
         ebreak_q       <= 1'b0;
         flush_req      <= 1'b0;
         csr_wr_en      <= 1'b0;
         csr_wr_addr    <= '0;
         csr_wr_data    <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         cmt_cause      <= '0;
         halt           <= 1'b0;
         halt_code      <= '0;
         err_flush_tmo  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (any_accept) begin
                  epc_q       <= acc_pc;
                  tval_q      <= acc_tval;
                  ebreak_q    <= acc_ebreak;
                  cmt_cause   <= {{(XLEN-5){1'b0}}, acc_cause};
                  flush_cnt_q <= '0;
                  flush_req   <= 1'b1;
                  state_q     <= StFlush;
                  if (acc_ebreak) begin
                     halt_code <= endcode;
                  end
               end
            end
            StFlush: begin
               if (flush_done) begin
                  flush_req <= 1'b0;
                  if (flush_tmo) begin
                     err_flush_tmo <= 1'b1;
                  end
                  if (ebreak_q) begin
                     halt    <= 1'b1;
                     state_q <= StHalt;
                  end else begin
                     csr_wr_en   <= 1'b1;
                     csr_wr_addr <= CSR_MEPC;
                     csr_wr_data <= epc_q;
                     state_q     <= StWrEpc;
                  end
               end else begin
                  flush_cnt_q <= flush_cnt_q + 4'd1;
               end
            end
            StWrEpc: begin
               csr_wr_addr <= CSR_MCAUSE;
               csr_wr_data <= cmt_cause;
               state_q     <= StWrCause;
            end
            StWrCause: begin
               csr_wr_addr <= CSR_MTVAL;
               csr_wr_data <= tval_q;
               state_q     <= StWrTval;
            end
            StWrTval: begin
               // Direct mode only: mode bits of mtvec are dropped, target frozen for the handshake.
               csr_wr_en      <= 1'b0;
               csr_wr_addr    <= '0;
               csr_wr_data    <= '0;
               redirect_valid <= 1'b1;
               redirect_pc    <= {csr_mtvec[XLEN-1:2], 2'b00};
               state_q        <= StRedir;
            end
            StRedir: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  redirect_pc    <= '0;
                  state_q        <= StIdle;
               end
            end
            StHalt: begin
               state_q <= StHalt;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exu_trap_ctrl.sv
// Directed bench for exu_trap_ctrl: inputs change on the falling edge, outputs are checked 1ns later.
module tb_exu_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_excp_valid = 1'b0, alu_excp_ready;
   logic        alu_excp_ebreak = 1'b0, alu_excp_ecall = 1'b0, alu_excp_illegal = 1'b0;
   logic [31:0] alu_excp_pc = '0;
   logic        lsu_excp_valid = 1'b0, lsu_excp_ready, lsu_excp_ld_mis = 1'b0;
   logic [31:0] lsu_excp_pc = '0, lsu_excp_badaddr = '0;
   logic        flush_req, flush_ack = 1'b1;
   logic        csr_wr_en;
   logic [11:0] csr_wr_addr;
   logic [31:0] csr_wr_data, csr_mtvec = '0;
   logic        redirect_valid, redirect_ready = 1'b1;
   logic [31:0] redirect_pc, endcode = '0;
   logic        commit_trap, halt, err_flush_tmo;
   logic [31:0] cmt_cause, halt_code;

   int n_run = 0;
   int n_fail = 0;

   exu_trap_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .alu_excp_valid   (alu_excp_valid),
      .alu_excp_ready   (alu_excp_ready),
      .alu_excp_ebreak  (alu_excp_ebreak),
      .alu_excp_ecall   (alu_excp_ecall),
      .alu_excp_illegal (alu_excp_illegal),
      .alu_excp_pc      (alu_excp_pc),
      .lsu_excp_valid   (lsu_excp_valid),
      .lsu_excp_ready   (lsu_excp_ready),
      .lsu_excp_ld_mis  (lsu_excp_ld_mis),
      .lsu_excp_pc      (lsu_excp_pc),
      .lsu_excp_badaddr (lsu_excp_badaddr),
      .flush_req        (flush_req),
      .flush_ack        (flush_ack),
      .csr_wr_en        (csr_wr_en),
      .csr_wr_addr      (csr_wr_addr),
      .csr_wr_data      (csr_wr_data),
      .csr_mtvec        (csr_mtvec),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .redirect_ready   (redirect_ready),
      .endcode          (endcode),
      .commit_trap      (commit_trap),
      .cmt_cause        (cmt_cause),
      .halt             (halt),
      .halt_code        (halt_code),
      .err_flush_tmo    (err_flush_tmo)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running exp finished");
      $fatal(1);
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_run++; if ({flush_req, csr_wr_en, redirect_valid, commit_trap, halt, err_flush_tmo} !== 6'b0) begin
         n_fail++; $display("FAIL rst_strobes got %b exp 000000",
            {flush_req, csr_wr_en, redirect_valid, commit_trap, halt, err_flush_tmo}); end
      n_run++; if ({cmt_cause, halt_code, redirect_pc, csr_wr_data} !== 128'h0) begin
         n_fail++; $display("FAIL rst_data got %h exp 0", {cmt_cause, halt_code, redirect_pc, csr_wr_data}); end
      n_run++; if ({lsu_excp_ready, alu_excp_ready} !== 2'b11) begin
         n_fail++; $display("FAIL rst_ready got %b exp 11", {lsu_excp_ready, alu_excp_ready}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_lsu_basic();
      flush_ack = 1'b1; redirect_ready = 1'b1; csr_mtvec = 32'h8000_0103;
      @(negedge clk);
      lsu_excp_valid = 1'b1; lsu_excp_ld_mis = 1'b1;
      lsu_excp_pc = 32'h8000_0010; lsu_excp_badaddr = 32'h8000_1003;
      #1;
      n_run++; if (lsu_excp_ready !== 1'b1) begin
         n_fail++; $display("FAIL lsu_ready got %b exp 1", lsu_excp_ready); end
      @(negedge clk); lsu_excp_valid = 1'b0; #1;
      n_run++; if ({flush_req, commit_trap, csr_wr_en} !== 3'b100) begin
         n_fail++; $display("FAIL lsu_flush got %b exp 100", {flush_req, commit_trap, csr_wr_en}); end
      n_run++; if (cmt_cause !== 32'd4) begin
         n_fail++; $display("FAIL lsu_cmt_cause got %h exp 4", cmt_cause); end
      @(negedge clk); #1;
      n_run++; if ({csr_wr_en, csr_wr_addr, csr_wr_data} !== {1'b1, 12'h341, 32'h8000_0010}) begin
         n_fail++; $display("FAIL lsu_wr_epc got %b/%h/%h exp 1/341/80000010", csr_wr_en, csr_wr_addr, csr_wr_data); end
      @(negedge clk); #1;
      n_run++; if ({csr_wr_en, csr_wr_addr, csr_wr_data} !== {1'b1, 12'h342, 32'd4}) begin
         n_fail++; $display("FAIL lsu_wr_cause got %b/%h/%h exp 1/342/4", csr_wr_en, csr_wr_addr, csr_wr_data); end
      @(negedge clk); #1;
      n_run++; if ({csr_wr_en, csr_wr_addr, csr_wr_data} !== {1'b1, 12'h343, 32'h8000_1003}) begin
         n_fail++; $display("FAIL lsu_wr_tval got %b/%h/%h exp 1/343/80001003", csr_wr_en, csr_wr_addr, csr_wr_data); end
      @(negedge clk); #1;
      n_run++; if ({redirect_valid, commit_trap, csr_wr_en} !== 3'b110) begin
         n_fail++; $display("FAIL lsu_redir got %b exp 110", {redirect_valid, commit_trap, csr_wr_en}); end
      n_run++; if (redirect_pc !== 32'h8000_0100) begin
         n_fail++; $display("FAIL lsu_redir_pc got %h exp 80000100", redirect_pc); end
      @(negedge clk); #1;
      n_run++; if ({redirect_valid, commit_trap, lsu_excp_ready} !== 3'b001) begin
         n_fail++; $display("FAIL lsu_done got %b exp 001", {redirect_valid, commit_trap, lsu_excp_ready}); end
   endtask

   task automatic test_arbitration();
      logic [43:0] exp_wr [6];
      logic [31:0] exp_cause [2];
      int widx = 0, ncommit = 0, commit1_cyc = -1, alu_acc_cyc = -1;
      logic alu_acc = 1'b0;
      exp_wr[0] = {12'h341, 32'h0000_1000}; exp_wr[1] = {12'h342, 32'd6};
      exp_wr[2] = {12'h343, 32'h0000_2002}; exp_wr[3] = {12'h341, 32'h0000_3000};
      exp_wr[4] = {12'h342, 32'd2};         exp_wr[5] = {12'h343, 32'h0};
      exp_cause[0] = 32'd6; exp_cause[1] = 32'd2;
      flush_ack = 1'b1; redirect_ready = 1'b1;
      @(negedge clk);
      lsu_excp_valid = 1'b1; lsu_excp_ld_mis = 1'b0;
      lsu_excp_pc = 32'h0000_1000; lsu_excp_badaddr = 32'h0000_2002;
      alu_excp_valid = 1'b1; alu_excp_illegal = 1'b1; alu_excp_ecall = 1'b1;
      alu_excp_pc = 32'h0000_3000;
      #1;
      n_run++; if ({lsu_excp_ready, alu_excp_ready} !== 2'b10) begin
         n_fail++; $display("FAIL arb_ready got %b exp 10", {lsu_excp_ready, alu_excp_ready}); end
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         lsu_excp_valid = 1'b0;
         if (alu_acc) alu_excp_valid = 1'b0;
         #1;
         if (csr_wr_en) begin
            n_run++;
            if (widx >= 6) begin
               n_fail++; $display("FAIL arb_extra_wr got %h/%h exp none", csr_wr_addr, csr_wr_data);
            end else if ({csr_wr_addr, csr_wr_data} !== exp_wr[widx]) begin
               n_fail++; $display("FAIL arb_wr%0d got %h/%h exp %h", widx, csr_wr_addr, csr_wr_data, exp_wr[widx]);
            end
            widx++;
         end
         if (commit_trap) begin
            n_run++;
            if (ncommit >= 2) begin
               n_fail++; $display("FAIL arb_extra_commit got %0d exp 2", ncommit + 1);
            end else if (cmt_cause !== exp_cause[ncommit]) begin
               n_fail++; $display("FAIL arb_cause%0d got %h exp %h", ncommit, cmt_cause, exp_cause[ncommit]);
            end
            if (ncommit == 0) commit1_cyc = cyc;
            ncommit++;
         end
         if (alu_excp_valid && alu_excp_ready) begin
            alu_acc = 1'b1; alu_acc_cyc = cyc;
         end
      end
      alu_excp_illegal = 1'b0; alu_excp_ecall = 1'b0;
      n_run++; if (ncommit !== 2) begin
         n_fail++; $display("FAIL arb_commits got %0d exp 2", ncommit); end
      n_run++; if (widx !== 6) begin
         n_fail++; $display("FAIL arb_writes got %0d exp 6", widx); end
      n_run++; if (alu_acc_cyc !== commit1_cyc + 1) begin
         n_fail++; $display("FAIL arb_b2b got %0d exp %0d", alu_acc_cyc, commit1_cyc + 1); end
   endtask

   task automatic test_flush_timeout();
      int nflush = 0, nwr = 0, ncommit = 0;
      logic err_early = 1'b0;
      flush_ack = 1'b0; redirect_ready = 1'b1;
      @(negedge clk);
      lsu_excp_valid = 1'b1; lsu_excp_ld_mis = 1'b0;
      lsu_excp_pc = 32'h0000_4000; lsu_excp_badaddr = 32'h0000_4006;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         lsu_excp_valid = 1'b0;
         #1;
         if (flush_req) begin
            nflush++;
            if (err_flush_tmo) err_early = 1'b1;
         end
         if (csr_wr_en) nwr++;
         if (commit_trap) ncommit++;
      end
      flush_ack = 1'b1;
      n_run++; if (nflush !== 15) begin
         n_fail++; $display("FAIL tmo_flush_cycles got %0d exp 15", nflush); end
      n_run++; if (err_early !== 1'b0) begin
         n_fail++; $display("FAIL tmo_err_early got %b exp 0", err_early); end
      n_run++; if (err_flush_tmo !== 1'b1) begin
         n_fail++; $display("FAIL tmo_err got %b exp 1", err_flush_tmo); end
      n_run++; if ({nwr, ncommit} !== {32'd3, 32'd1}) begin
         n_fail++; $display("FAIL tmo_complete got %0d writes %0d commits exp 3/1", nwr, ncommit); end
   endtask

   task automatic test_redirect_stall();
      logic found = 1'b0;
      flush_ack = 1'b1; redirect_ready = 1'b0; csr_mtvec = 32'h0000_2005;
      @(negedge clk);
      alu_excp_valid = 1'b1; alu_excp_ecall = 1'b1; alu_excp_pc = 32'h0000_5000;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
         @(negedge clk);
         alu_excp_valid = 1'b0;
         #1;
         if (redirect_valid) found = 1'b1;
      end
      alu_excp_ecall = 1'b0;
      n_run++; if (!found) begin
         n_fail++; $display("FAIL stall_reach_redir got 0 exp 1"); end
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            @(negedge clk); csr_mtvec = 32'hFFFF_0000 + 32'(i); #1;
         end
         n_run++; if ({redirect_valid, commit_trap, redirect_pc} !== {2'b10, 32'h0000_2004}) begin
            n_fail++; $display("FAIL stall_hold%0d got %b%b/%h exp 10/00002004", i, redirect_valid, commit_trap, redirect_pc); end
      end
      @(negedge clk); redirect_ready = 1'b1; #1;
      n_run++; if ({redirect_valid, commit_trap, redirect_pc} !== {2'b11, 32'h0000_2004}) begin
         n_fail++; $display("FAIL stall_commit got %b%b/%h exp 11/00002004", redirect_valid, commit_trap, redirect_pc); end
      n_run++; if (cmt_cause !== 32'd11) begin
         n_fail++; $display("FAIL stall_cause got %h exp b", cmt_cause); end
      @(negedge clk); #1;
      n_run++; if ({redirect_valid, commit_trap, lsu_excp_ready} !== 3'b001) begin
         n_fail++; $display("FAIL stall_done got %b exp 001", {redirect_valid, commit_trap, lsu_excp_ready}); end
   endtask

   task automatic test_reset_mid();
      logic found = 1'b0, bad = 1'b0;
      flush_ack = 1'b1; redirect_ready = 1'b1;
      @(negedge clk);
      lsu_excp_valid = 1'b1; lsu_excp_ld_mis = 1'b1;
      lsu_excp_pc = 32'h0000_7000; lsu_excp_badaddr = 32'h0000_7001;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
         @(negedge clk);
         lsu_excp_valid = 1'b0;
         #1;
         if (csr_wr_en && csr_wr_addr == 12'h342) found = 1'b1;
      end
      n_run++; if (!found) begin
         n_fail++; $display("FAIL rmid_reach_cause got 0 exp 1"); end
      rst = 1'b0;
      #1;
      n_run++; if ({csr_wr_en, flush_req, redirect_valid, commit_trap, err_flush_tmo} !== 5'b0) begin
         n_fail++; $display("FAIL rmid_async got %b exp 00000",
            {csr_wr_en, flush_req, redirect_valid, commit_trap, err_flush_tmo}); end
      n_run++; if ({csr_wr_addr, csr_wr_data, cmt_cause} !== 76'h0) begin
         n_fail++; $display("FAIL rmid_data got %h/%h/%h exp 0", csr_wr_addr, csr_wr_data, cmt_cause); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk); #1;
         if (csr_wr_en || redirect_valid || commit_trap || flush_req) bad = 1'b1;
      end
      n_run++; if (bad !== 1'b0) begin
         n_fail++; $display("FAIL rmid_quiet got %b exp 0", bad); end
      n_run++; if ({lsu_excp_ready, alu_excp_ready} !== 2'b11) begin
         n_fail++; $display("FAIL rmid_ready got %b exp 11", {lsu_excp_ready, alu_excp_ready}); end
   endtask

   task automatic test_ebreak_halt();
      logic bad = 1'b0;
      flush_ack = 1'b1; redirect_ready = 1'b1;
      @(negedge clk);
      alu_excp_valid = 1'b1; alu_excp_ebreak = 1'b1; alu_excp_pc = 32'h0000_6000; endcode = 32'h0;
      #1;
      n_run++; if (alu_excp_ready !== 1'b1) begin
         n_fail++; $display("FAIL ebrk_ready got %b exp 1", alu_excp_ready); end
      @(negedge clk); alu_excp_valid = 1'b0; alu_excp_ebreak = 1'b0; endcode = 32'hDEAD_BEEF; #1;
      n_run++; if ({flush_req, commit_trap, csr_wr_en} !== 3'b110) begin
         n_fail++; $display("FAIL ebrk_flush got %b exp 110", {flush_req, commit_trap, csr_wr_en}); end
      n_run++; if (cmt_cause !== 32'd3) begin
         n_fail++; $display("FAIL ebrk_cause got %h exp 3", cmt_cause); end
      @(negedge clk); #1;
      n_run++; if ({halt, flush_req, csr_wr_en, commit_trap, redirect_valid} !== 5'b10000) begin
         n_fail++; $display("FAIL ebrk_halt got %b exp 10000",
            {halt, flush_req, csr_wr_en, commit_trap, redirect_valid}); end
      n_run++; if (halt_code !== 32'h0) begin
         n_fail++; $display("FAIL ebrk_code got %h exp 0", halt_code); end
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         lsu_excp_valid = 1'b1; alu_excp_valid = 1'b1; alu_excp_illegal = 1'b1;
         #1;
         if (lsu_excp_ready || alu_excp_ready || csr_wr_en || redirect_valid || commit_trap || flush_req)
            bad = 1'b1;
      end
      n_run++; if (bad !== 1'b0) begin
         n_fail++; $display("FAIL ebrk_terminal got %b exp 0", bad); end
      n_run++; if ({halt, halt_code} !== {1'b1, 32'h0}) begin
         n_fail++; $display("FAIL ebrk_sticky got %b/%h exp 1/0", halt, halt_code); end
      @(negedge clk);
      lsu_excp_valid = 1'b0; alu_excp_valid = 1'b0; alu_excp_illegal = 1'b0;
      rst = 1'b0; #1;
      n_run++; if ({halt, lsu_excp_ready} !== 2'b01) begin
         n_fail++; $display("FAIL ebrk_reset got %b exp 01", {halt, lsu_excp_ready}); end
      @(negedge clk); rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lsu_basic();
      test_arbitration();
      test_flush_timeout();
      test_redirect_stall();
      test_reset_mid();
      test_ebreak_halt();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
